// File: rtl/ps2_command_sender.sv
// PS/2 host-to-device command transmitter.
// Sends one command byte using the inhibit / request-to-send sequence,
// clocks the frame out on device falling edges and checks the ACK bit.
// The pins are open-drain: the top level builds pin = oe ? 1'b0 : 'bz.
module ps2_command_sender #(
    parameter int unsigned INHIBIT_CYCLES = 5000,
    parameter int unsigned SETUP_CYCLES   = 100,
    parameter int unsigned START_TIMEOUT  = 750000,
    parameter int unsigned PACKET_TIMEOUT = 100000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       send_command,
    input  logic [7:0] the_command,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       ps2_clk_oe,
    output logic       ps2_dat_oe,
    output logic       busy,
    output logic       command_was_sent,
    output logic       error_timed_out,
    output logic       error_no_ack
);

    localparam int unsigned TIMEOUT_MAX = (START_TIMEOUT > PACKET_TIMEOUT) ? START_TIMEOUT : PACKET_TIMEOUT;
    localparam int unsigned DELAY_MAX   = (INHIBIT_CYCLES > SETUP_CYCLES) ? INHIBIT_CYCLES : SETUP_CYCLES;
    localparam int unsigned COUNT_MAX   = (TIMEOUT_MAX > DELAY_MAX) ? TIMEOUT_MAX : DELAY_MAX;
    localparam int unsigned TW          = $clog2(COUNT_MAX + 1);

    localparam logic [TW-1:0] INHIBIT_LAST = TW'(INHIBIT_CYCLES - 1);
    localparam logic [TW-1:0] SETUP_LAST   = TW'(SETUP_CYCLES - 1);
    localparam logic [TW-1:0] START_LIMIT  = TW'(START_TIMEOUT);
    localparam logic [TW-1:0] PACKET_LIMIT = TW'(PACKET_TIMEOUT);
    localparam logic [TW-1:0] COUNT_SAT    = TW'(COUNT_MAX);

    typedef enum logic [3:0] {
        IDLE,
        INHIBIT,
        REQ,
        WAIT_DEV,
        SEND,
        ACK,
        WAIT_IDLE,
        DONE,
        ERR_TO,
        ERR_NA
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [9:0]    frame_q, frame_d;
    logic          clk_oe_q, clk_oe_d;
    logic          dat_oe_q, dat_oe_d;

    logic          clk_meta_q, clk_sync_q, clk_prev_q;
    logic          dat_meta_q, dat_sync_q;
    logic          fall;
    logic [TW-1:0] timer_inc;

    // Two-flop synchronisers on both pins plus a delayed copy of the clock for edge detection.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            clk_meta_q <= 1'b1;
            clk_sync_q <= 1'b1;
            clk_prev_q <= 1'b1;
            dat_meta_q <= 1'b1;
            dat_sync_q <= 1'b1;
        end else begin
            clk_meta_q <= ps2_clk_in;
            clk_sync_q <= clk_meta_q;
            clk_prev_q <= clk_sync_q;
            dat_meta_q <= ps2_dat_in;
            dat_sync_q <= dat_meta_q;
        end
    end

    assign fall      = clk_prev_q & ~clk_sync_q;
    assign timer_inc = (timer_q == COUNT_SAT) ? timer_q : timer_q + TW'(1);

    // State, timer, frame and registered open-drain enables.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            bit_cnt_q <= '0;
            frame_q   <= '0;
            clk_oe_q  <= 1'b0;
            dat_oe_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            bit_cnt_q <= bit_cnt_d;
            frame_q   <= frame_d;
            clk_oe_q  <= clk_oe_d;
            dat_oe_q  <= dat_oe_d;
        end
    end

    // Next-state logic; the enables are computed one cycle ahead so the pins come straight from flops.
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        bit_cnt_d = bit_cnt_q;
        frame_d   = frame_q;
        clk_oe_d  = clk_oe_q;
        dat_oe_d  = dat_oe_q;

        case (state_q)
            IDLE: begin
                clk_oe_d = 1'b0;
                dat_oe_d = 1'b0;
                if (send_command) begin
                    frame_d   = {1'b1, ~^the_command, the_command};
                    bit_cnt_d = '0;
                    timer_d   = '0;
                    clk_oe_d  = 1'b1;
                    state_d   = INHIBIT;
                end
            end

            INHIBIT: begin
                if (timer_q >= INHIBIT_LAST) begin
                    timer_d  = '0;
                    dat_oe_d = 1'b1;
                    state_d  = REQ;
                end else begin
                    timer_d = timer_inc;
                end
            end

            REQ: begin
                if (timer_q >= SETUP_LAST) begin
                    timer_d  = '0;
                    clk_oe_d = 1'b0;
                    state_d  = WAIT_DEV;
                end else begin
                    timer_d = timer_inc;
                end
            end

            WAIT_DEV: begin
                if (fall) begin
                    dat_oe_d  = ~frame_q[0];
                    bit_cnt_d = 4'd1;
                    timer_d   = '0;
                    state_d   = SEND;
                end else if (timer_inc >= START_LIMIT) begin
                    clk_oe_d = 1'b0;
                    dat_oe_d = 1'b0;
                    state_d  = ERR_TO;
                end else begin
                    timer_d = timer_inc;
                end
            end

            SEND: begin
                if (timer_inc >= PACKET_LIMIT) begin
                    clk_oe_d = 1'b0;
                    dat_oe_d = 1'b0;
                    state_d  = ERR_TO;
                end else begin
                    timer_d = timer_inc;
                    if (fall) begin
                        dat_oe_d  = ~frame_q[bit_cnt_q];
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd9) begin
                            state_d = ACK;
                        end
                    end
                end
            end

            ACK: begin
                if (timer_inc >= PACKET_LIMIT) begin
                    clk_oe_d = 1'b0;
                    dat_oe_d = 1'b0;
                    state_d  = ERR_TO;
                end else begin
                    timer_d = timer_inc;
                    if (fall) begin
                        dat_oe_d = 1'b0;
                        state_d  = dat_sync_q ? ERR_NA : WAIT_IDLE;
                    end
                end
            end

            WAIT_IDLE: begin
                if (timer_inc >= PACKET_LIMIT) begin
                    clk_oe_d = 1'b0;
                    dat_oe_d = 1'b0;
                    state_d  = ERR_TO;
                end else begin
                    timer_d = timer_inc;
                    if (clk_sync_q && dat_sync_q) begin
                        state_d = DONE;
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            ERR_TO, ERR_NA: begin
                clk_oe_d = 1'b0;
                dat_oe_d = 1'b0;
                state_d  = IDLE;
            end

            default: begin
                clk_oe_d = 1'b0;
                dat_oe_d = 1'b0;
                state_d  = IDLE;
            end
        endcase
    end

    assign ps2_clk_oe       = clk_oe_q;
    assign ps2_dat_oe       = dat_oe_q;
    assign busy             = (state_q != IDLE);
    assign command_was_sent = (state_q == DONE);
    assign error_timed_out  = (state_q == ERR_TO);
    assign error_no_ack     = (state_q == ERR_NA);

endmodule

// File: tb/tb_ps2_command_sender.sv
// Bench for ps2_command_sender: a behavioural PS/2 device clocks frames out of the
// host, and a scoreboard of expected frames/outcomes is checked as transfers finish.
`timescale 1ns/1ps
module tb_ps2_command_sender;

    localparam int unsigned INH  = 20;
    localparam int unsigned SET  = 4;
    localparam int unsigned STO  = 200;
    localparam int unsigned PTO  = 2000;
    localparam int          HALF = 50;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       send_command = 1'b0;
    logic [7:0] the_command = '0;
    logic       dev_clk_low = 1'b0;
    logic       dev_dat_low = 1'b0;
    logic       ps2_clk_pin, ps2_dat_pin;
    logic       ps2_clk_oe, ps2_dat_oe, busy;
    logic       command_was_sent, error_timed_out, error_no_ack;

    assign ps2_clk_pin = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_dat_pin = ~(ps2_dat_oe | dev_dat_low);

    always #10 clock = ~clock;

    ps2_command_sender #(
        .INHIBIT_CYCLES(INH),
        .SETUP_CYCLES  (SET),
        .START_TIMEOUT (STO),
        .PACKET_TIMEOUT(PTO)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .send_command    (send_command),
        .the_command     (the_command),
        .ps2_clk_in      (ps2_clk_pin),
        .ps2_dat_in      (ps2_dat_pin),
        .ps2_clk_oe      (ps2_clk_oe),
        .ps2_dat_oe      (ps2_dat_oe),
        .busy            (busy),
        .command_was_sent(command_was_sent),
        .error_timed_out (error_timed_out),
        .error_no_ack    (error_no_ack)
    );

    typedef struct {
        logic [10:0] frame;
        int          outcome;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   done_cnt = 0;
    int   to_cnt = 0;
    int   na_cnt = 0;

    // Count every cycle each completion output is high.
    always @(negedge clock) begin
        if (command_was_sent) done_cnt++;
        if (error_timed_out)  to_cnt++;
        if (error_no_ack)     na_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send_cmd(input logic [7:0] c, input int outcome, input bit push);
        exp_t e;
        @(negedge clock);
        send_command = 1'b1;
        the_command  = c;
        if (push) begin
            e.frame   = {1'b1, ~^c, c, 1'b0};
            e.outcome = outcome;
            exp_q.push_back(e);
        end
        @(negedge clock);
        send_command = 1'b0;
    endtask

    // Device side: waits for the request, then generates the PS/2 clock and samples
    // each bit on the rising edge. abort_fall > 0 stops with the clock held low.
    task automatic dev_run(input bit ack_low, input int abort_fall,
                           output logic [10:0] bits, output bit ok);
        int cyc;
        bits = '0;
        ok   = 1'b1;
        cyc  = 0;
        while (ps2_clk_oe !== 1'b1 && cyc < 100) begin
            @(negedge clock);
            cyc++;
        end
        if (ps2_clk_oe !== 1'b1) begin
            ok = 1'b0;
            return;
        end
        cyc = 0;
        while (ps2_clk_oe !== 1'b0 && cyc < 100) begin
            @(negedge clock);
            cyc++;
        end
        if (ps2_clk_oe !== 1'b0) begin
            ok = 1'b0;
            return;
        end
        repeat (10) @(negedge clock);
        bits[0] = ps2_dat_pin;
        for (int k = 1; k <= 10; k++) begin
            dev_clk_low = 1'b1;
            repeat (HALF) @(negedge clock);
            if (k == abort_fall) return;
            dev_clk_low = 1'b0;
            @(negedge clock);
            bits[k] = ps2_dat_pin;
            repeat (HALF - 1) @(negedge clock);
        end
        dev_dat_low = ack_low;
        repeat (10) @(negedge clock);
        dev_clk_low = 1'b1;
        repeat (HALF) @(negedge clock);
        dev_clk_low = 1'b0;
        repeat (5) @(negedge clock);
        dev_dat_low = 1'b0;
    endtask

    task automatic wait_outcome(output int code);
        int cyc;
        code = -1;
        cyc  = 0;
        while (cyc < 4000) begin
            @(negedge clock);
            cyc++;
            if (command_was_sent) begin code = 0; break; end
            if (error_timed_out)  begin code = 1; break; end
            if (error_no_ack)     begin code = 2; break; end
        end
    endtask

    task automatic inject_while_busy(input bit enable);
        if (enable) begin
            repeat (5) @(negedge clock);
            send_command = 1'b1;
            the_command  = 8'h00;
            @(negedge clock);
            send_command = 1'b0;
            repeat (300) @(negedge clock);
            send_command = 1'b1;
            the_command  = 8'h00;
            @(negedge clock);
            send_command = 1'b0;
        end
    endtask

    task automatic do_xfer(input logic [7:0] c, input bit ack_low, input bit inject);
        logic [10:0] bits;
        bit          ok;
        int          code;
        int          d0, t0, a0;
        exp_t        e;
        d0 = done_cnt; t0 = to_cnt; a0 = na_cnt;
        send_cmd(c, ack_low ? 0 : 2, 1'b1);
        fork
            dev_run(ack_low, 0, bits, ok);
            wait_outcome(code);
            inject_while_busy(inject);
        join
        repeat (5) @(negedge clock);
        check("scoreboard_nonempty", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("device_handshake", 32'(ok), 32'd1);
            check("wire_frame", 32'(bits), 32'(e.frame));
            check("outcome", code, e.outcome);
            check("done_pulses", done_cnt - d0, (e.outcome == 0) ? 1 : 0);
            check("noack_pulses", na_cnt - a0, (e.outcome == 2) ? 1 : 0);
            check("timeout_pulses", to_cnt - t0, 0);
        end
        check("busy_after", 32'(busy), 32'd0);
        check("oe_after", 32'({ps2_clk_oe, ps2_dat_oe}), 32'd0);
    endtask

    initial begin
        #(2_000_000);
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          n, both, first_dat, cyc, code, d0, t0, a0;
        logic [10:0] bits;
        bit          ok;
        exp_t        e;

        // Reset state
        #1 reset = 1'b1;
        repeat (3) @(negedge clock);
        check("reset_outputs",
              32'({ps2_clk_oe, ps2_dat_oe, busy, command_was_sent, error_timed_out, error_no_ack}),
              32'd0);
        reset = 1'b0;
        repeat (10) @(negedge clock);
        check("post_reset_idle", 32'({busy, ps2_clk_oe, ps2_dat_oe}), 32'd0);
        check("post_reset_no_pulses", done_cnt + to_cnt + na_cnt, 0);

        // Normal transfers, the first with send_command pulses while busy
        do_xfer(8'hED, 1'b1, 1'b1);
        do_xfer(8'h01, 1'b1, 1'b0);
        do_xfer(8'hFF, 1'b1, 1'b0);
        do_xfer(8'h00, 1'b1, 1'b0);

        // Request timing, then start timeout with a silent device
        d0 = done_cnt; t0 = to_cnt; a0 = na_cnt;
        send_cmd(8'h55, 1, 1'b1);
        n = 0; both = 0; first_dat = -1;
        while (ps2_clk_oe === 1'b1 && n < 100) begin
            if (ps2_dat_oe === 1'b1) begin
                if (first_dat < 0) first_dat = n;
                both++;
            end
            n++;
            @(negedge clock);
        end
        check("req_clk_low_cycles", n, INH + SET);
        check("req_dat_low_cycles", both, SET);
        check("req_dat_low_start", first_dat, INH);
        check("wait_dev_dat_low", 32'(ps2_dat_oe), 32'd1);
        cyc = 0;
        while (error_timed_out !== 1'b1 && cyc < 1000) begin
            @(negedge clock);
            cyc++;
        end
        check("start_timeout_cycles", cyc, STO);
        check("timeout_oe_released", 32'({ps2_clk_oe, ps2_dat_oe}), 32'd0);
        code = (error_timed_out === 1'b1) ? 1 : -1;
        repeat (3) @(negedge clock);
        check("scoreboard_nonempty", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("outcome", code, e.outcome);
        end
        check("timeout_pulses", to_cnt - t0, 1);
        check("timeout_no_other_pulse", (done_cnt - d0) + (na_cnt - a0), 0);
        check("busy_after", 32'(busy), 32'd0);

        // Device leaves data high in the ACK slot
        do_xfer(8'hF4, 1'b0, 1'b0);

        // Reset during SEND while bit 4 (a 0) is on the wire
        d0 = done_cnt; t0 = to_cnt; a0 = na_cnt;
        send_cmd(8'h2C, 0, 1'b0);
        dev_run(1'b1, 5, bits, ok);
        check("abort_handshake", 32'(ok), 32'd1);
        check("abort_pre_dat_oe", 32'(ps2_dat_oe), 32'd1);
        check("abort_pre_busy", 32'(busy), 32'd1);
        #3 reset = 1'b1;
        #1;
        check("abort_oe_dropped", 32'({ps2_clk_oe, ps2_dat_oe}), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        dev_clk_low = 1'b0;
        dev_dat_low = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        repeat (50) @(negedge clock);
        check("abort_no_pulses", (done_cnt - d0) + (to_cnt - t0) + (na_cnt - a0), 0);
        check("abort_idle", 32'({busy, ps2_clk_oe, ps2_dat_oe}), 32'd0);

        // Recovery after the aborted transfer
        do_xfer(8'hAB, 1'b1, 1'b0);

        check("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
